// File: rtl/out_channel_checker_if.sv
// Output-channel handshake between the program-execution core (master) and the checker (slave).
interface out_channel_checker_if #(
    parameter int Width = 12
) ();
    logic             outValid;
    logic [Width-1:0] outData;
    logic             outReady;

    modport master (output outValid, output outData, input outReady);
    modport slave  (input outValid, input outData, output outReady);
endinterface

// File: rtl/out_channel_checker.sv
// Consumer end of the test program's output channel: compares received words against a loaded table.
// Optional RUN-state watchdog with a timedOut output is enabled by defining CHECKER_TIMEOUT_EN.
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NExpected          = 100,
    parameter int CountWidth         = 16
`ifdef CHECKER_TIMEOUT_EN
    ,
    parameter int TimeoutCycles      = 1000
`endif
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          loadEnable,
    input  logic [CountWidth-1:0]         loadAddr,
    input  logic [MemoryElementWidth-1:0] loadData,
    input  logic [CountWidth-1:0]         expectedCount,
    input  logic                          start,
    out_channel_checker_if.slave          channel,
    input  logic                          programDone,
    output logic                          finished,
    output logic                          success,
    output logic [CountWidth-1:0]         received,
    output logic [CountWidth-1:0]         firstBad,
    output logic                          mismatch
`ifdef CHECKER_TIMEOUT_EN
    ,
    output logic                          timedOut
`endif
);

    localparam int AddrWidth = (NExpected > 1) ? $clog2(NExpected) : 1;
    localparam logic [CountWidth-1:0] TableDepth = CountWidth'(NExpected);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                        state_q, state_d;
    logic                          ready_q;
    logic [CountWidth-1:0]         limit_q, limit_d;
    logic [CountWidth-1:0]         received_q, received_d;
    logic [CountWidth-1:0]         first_bad_q, first_bad_d;
    logic                          mismatch_q, mismatch_d;
    logic                          finished_q, finished_d;
    logic                          success_q, success_d;
    logic                          transfer;
    logic                          word_bad;
    logic [MemoryElementWidth-1:0] expected_word;

    // The table survives reset so a run can be repeated without reloading.
    logic [MemoryElementWidth-1:0] expected_mem [NExpected];

`ifdef CHECKER_TIMEOUT_EN
    localparam int TimerWidth = $clog2(TimeoutCycles + 1);
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic                  timed_out_q, timed_out_d;
`endif

    always_ff @(posedge clock) begin
        if (state_q == IDLE && loadEnable && loadAddr < TableDepth) begin
            expected_mem[loadAddr[AddrWidth-1:0]] <= loadData;
        end
    end

    assign expected_word    = expected_mem[received_q[AddrWidth-1:0]];
    assign transfer         = channel.outValid && ready_q;
    assign channel.outReady = ready_q;

    // A word arriving with programDone is scored before success is decided.
    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        received_d  = received_q;
        first_bad_d = first_bad_q;
        mismatch_d  = mismatch_q;
        finished_d  = finished_q;
        success_d   = success_q;
        word_bad    = 1'b0;
`ifdef CHECKER_TIMEOUT_EN
        timer_d     = timer_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    limit_d     = (expectedCount < TableDepth) ? expectedCount : TableDepth;
                    received_d  = '0;
                    first_bad_d = '0;
                    mismatch_d  = 1'b0;
                    finished_d  = 1'b0;
                    success_d   = 1'b0;
                    state_d     = RUN;
`ifdef CHECKER_TIMEOUT_EN
                    timer_d     = '0;
                    timed_out_d = 1'b0;
`endif
                end
            end
            RUN: begin
                if (transfer) begin
                    word_bad = (received_q >= limit_q) || (channel.outData != expected_word);
                    if (word_bad && !mismatch_q) begin
                        mismatch_d  = 1'b1;
                        first_bad_d = received_q;
                    end
                    if (received_q != '1) begin
                        received_d = received_q + CountWidth'(1);
                    end
                end
                if (programDone) begin
                    state_d    = DONE;
                    finished_d = 1'b1;
                    success_d  = !mismatch_d && (received_d == limit_q);
                end
`ifdef CHECKER_TIMEOUT_EN
                else if (timer_q == TimerWidth'(TimeoutCycles - 1)) begin
                    state_d     = DONE;
                    finished_d  = 1'b1;
                    success_d   = 1'b0;
                    timed_out_d = 1'b1;
                end else begin
                    timer_d = timer_q + TimerWidth'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            limit_q     <= '0;
            received_q  <= '0;
            first_bad_q <= '0;
            mismatch_q  <= 1'b0;
            finished_q  <= 1'b0;
            success_q   <= 1'b0;
`ifdef CHECKER_TIMEOUT_EN
            timer_q     <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == RUN);
            limit_q     <= limit_d;
            received_q  <= received_d;
            first_bad_q <= first_bad_d;
            mismatch_q  <= mismatch_d;
            finished_q  <= finished_d;
            success_q   <= success_d;
`ifdef CHECKER_TIMEOUT_EN
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign finished = finished_q;
    assign success  = success_q;
    assign received = received_q;
    assign firstBad = first_bad_q;
    assign mismatch = mismatch_q;
`ifdef CHECKER_TIMEOUT_EN
    assign timedOut = timed_out_q;
`endif

endmodule
